// File: rtl/vs_pkg.sv
// Shared types and constants for the vertex shader: vertex word layout,
// output coordinate widths and the transformed-vertex payload.
package vs_pkg;

    localparam int unsigned ADDR_W     = 20;
    localparam int unsigned VTX_W      = 72;
    localparam int unsigned COORD_IN_W = 16;
    localparam int unsigned X_LSB      = 56;
    localparam int unsigned Y_LSB      = 40;
    localparam int unsigned Z_LSB      = 24;
    localparam int unsigned COLOR_LSB  = 0;

    localparam int unsigned SCR_W   = 12;
    localparam int unsigned DEPTH_W = 21;
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned MATH_W  = 34;

    typedef struct packed {
        logic [SCR_W-1:0]   x;
        logic [SCR_W-1:0]   y;
        logic [DEPTH_W-1:0] depth;
        logic [COLOR_W-1:0] color;
    } vertex_out_t;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
    } rd_tag_t;

    // Saturate a signed screen coordinate into [0, max_v].
    function automatic logic [SCR_W-1:0] clamp_coord(input logic signed [MATH_W-1:0] v,
                                                     input logic signed [MATH_W-1:0] max_v);
        logic [SCR_W-1:0] r;
        if (v[MATH_W-1]) begin
            r = '0;
        end else if (v > max_v) begin
            r = max_v[SCR_W-1:0];
        end else begin
            r = v[SCR_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vs_transform.sv
// Single-vertex registered transform: scale, shift, offset and clamp to screen,
// biased depth, colour pass-through. Slot tag travels alongside.
module vs_transform
    import vs_pkg::*;
#(
    parameter int unsigned SCALE    = 256,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned X_OFF    = 960,
    parameter int unsigned Y_OFF    = 540,
    parameter int unsigned SCREEN_W = 1920,
    parameter int unsigned SCREEN_H = 1080
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic [VTX_W-1:0]  in_word,
    output logic              out_valid,
    output logic [SLOT_W-1:0] out_slot,
    output vertex_out_t       out_vtx
);

    localparam logic signed [MATH_W-1:0] SCALE_S = MATH_W'(SCALE);
    localparam logic signed [MATH_W-1:0] XOFF_S  = MATH_W'(X_OFF);
    localparam logic signed [MATH_W-1:0] YOFF_S  = MATH_W'(Y_OFF);
    localparam logic signed [MATH_W-1:0] XMAX_S  = MATH_W'(SCREEN_W - 1);
    localparam logic signed [MATH_W-1:0] YMAX_S  = MATH_W'(SCREEN_H - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_BIAS = {1'b1, {(DEPTH_W-1){1'b0}}};

    logic signed [MATH_W-1:0] x_ext, y_ext, x_scaled, y_scaled, sx, sy;
    vertex_out_t              vtx_c;

    always_comb begin
        x_ext    = $signed({{(MATH_W-COORD_IN_W){in_word[X_LSB+COORD_IN_W-1]}},
                            in_word[X_LSB +: COORD_IN_W]});
        y_ext    = $signed({{(MATH_W-COORD_IN_W){in_word[Y_LSB+COORD_IN_W-1]}},
                            in_word[Y_LSB +: COORD_IN_W]});
        x_scaled = (x_ext * SCALE_S) >>> FRAC;
        y_scaled = (y_ext * SCALE_S) >>> FRAC;
        sx       = x_scaled + XOFF_S;
        // Screen y grows downward, so model y is subtracted from the offset.
        sy       = YOFF_S - y_scaled;

        vtx_c.x     = clamp_coord(sx, XMAX_S);
        vtx_c.y     = clamp_coord(sy, YMAX_S);
        vtx_c.depth = DEPTH_BIAS + {{(DEPTH_W-COORD_IN_W){in_word[Z_LSB+COORD_IN_W-1]}},
                                    in_word[Z_LSB +: COORD_IN_W]};
        vtx_c.color = in_word[COLOR_LSB +: COLOR_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_slot  <= '0;
            out_vtx   <= '0;
        end else begin
            out_valid <= in_valid;
            out_slot  <= in_slot;
            out_vtx   <= vtx_c;
        end
    end

endmodule

// File: rtl/vertex_shader.sv
// Vertex shader: issues SRAM reads for three vertex indices per triangle,
// transforms each returned vertex and presents the triangle with data_ready.
module vertex_shader
    import vs_pkg::*;
#(
    parameter int unsigned SRAM_LAT = 2,
    parameter int unsigned SCALE    = 256,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned X_OFF    = 960,
    parameter int unsigned Y_OFF    = 540,
    parameter int unsigned SCREEN_W = 1920,
    parameter int unsigned SCREEN_H = 1080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               to_shader_valid,
    input  logic [ADDR_W-1:0]  to_shader_vertice_info,
    output logic [ADDR_W-1:0]  address_sram_get_vertex,
    output logic               sram_rd_en,
    input  logic [VTX_W-1:0]   sram_rd_data,
    output logic [SCR_W-1:0]   vertice1_x_update,
    output logic [SCR_W-1:0]   vertice1_y_update,
    output logic [DEPTH_W-1:0] vertice1_depth_update,
    output logic [COLOR_W-1:0] vertice1_color_update,
    output logic [SCR_W-1:0]   vertice2_x_update,
    output logic [SCR_W-1:0]   vertice2_y_update,
    output logic [DEPTH_W-1:0] vertice2_depth_update,
    output logic [COLOR_W-1:0] vertice2_color_update,
    output logic [SCR_W-1:0]   vertice3_x_update,
    output logic [SCR_W-1:0]   vertice3_y_update,
    output logic [DEPTH_W-1:0] vertice3_depth_update,
    output logic [COLOR_W-1:0] vertice3_color_update,
    output logic               data_ready,
    output logic               overrun
);

    logic [SLOT_W-1:0] slot_q;
    rd_tag_t           tag_q [0:SRAM_LAT];
    logic              xf_valid;
    logic [SLOT_W-1:0] xf_slot;
    vertex_out_t       xf_vtx;
    vertex_out_t       stage_q [0:1];
    logic [1:0]        staged_q;
    vertex_out_t       out_q [0:2];
    logic              clr_pend_q;
    logic              tags_busy_c, in_flight_c, new_tri_c, viol_c, commit_c;

    // A new triangle arriving while the previous one still has work pending is an overrun.
    always_comb begin
        tags_busy_c = 1'b0;
        for (int unsigned i = 0; i <= SRAM_LAT; i++) begin
            tags_busy_c = tags_busy_c | tag_q[i].valid;
        end
        in_flight_c = tags_busy_c | xf_valid | (|staged_q);
        new_tri_c   = to_shader_valid && (slot_q == '0);
        viol_c      = new_tri_c && in_flight_c;
        commit_c    = xf_valid && (xf_slot == SLOT_W'(2)) && (staged_q == 2'b11);
    end

    vs_transform #(
        .SCALE    (SCALE),
        .FRAC     (FRAC),
        .X_OFF    (X_OFF),
        .Y_OFF    (Y_OFF),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_transform (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (tag_q[SRAM_LAT].valid && !viol_c),
        .in_slot   (tag_q[SRAM_LAT].slot),
        .in_word   (sram_rd_data),
        .out_valid (xf_valid),
        .out_slot  (xf_slot),
        .out_vtx   (xf_vtx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q                  <= '0;
            address_sram_get_vertex <= '0;
            sram_rd_en              <= 1'b0;
            for (int unsigned i = 0; i <= SRAM_LAT; i++) tag_q[i] <= '0;
            stage_q[0]              <= '0;
            stage_q[1]              <= '0;
            staged_q                <= '0;
            for (int unsigned i = 0; i < 3; i++) out_q[i] <= '0;
            data_ready              <= 1'b0;
            clr_pend_q              <= 1'b0;
            overrun                 <= 1'b0;
        end else begin
            sram_rd_en <= to_shader_valid;
            if (to_shader_valid) begin
                address_sram_get_vertex <= to_shader_vertice_info;
                slot_q <= (slot_q == SLOT_W'(2)) ? '0 : slot_q + SLOT_W'(1);
            end

            tag_q[0].valid <= to_shader_valid;
            tag_q[0].slot  <= slot_q;
            for (int unsigned i = 1; i <= SRAM_LAT; i++) begin
                tag_q[i] <= viol_c ? '0 : tag_q[i-1];
            end

            if (xf_valid && (xf_slot != SLOT_W'(2))) stage_q[xf_slot[0]] <= xf_vtx;
            if (viol_c || commit_c) begin
                staged_q <= '0;
            end else if (xf_valid && (xf_slot != SLOT_W'(2))) begin
                staged_q[xf_slot[0]] <= 1'b1;
            end

            // A commit coinciding with a new triangle wins; the clear follows one edge later.
            if (commit_c) begin
                out_q[0]   <= stage_q[0];
                out_q[1]   <= stage_q[1];
                out_q[2]   <= xf_vtx;
                data_ready <= 1'b1;
            end else if (new_tri_c || clr_pend_q) begin
                data_ready <= 1'b0;
            end
            clr_pend_q <= commit_c && new_tri_c;

            if (viol_c) overrun <= 1'b1;
        end
    end

    assign vertice1_x_update     = out_q[0].x;
    assign vertice1_y_update     = out_q[0].y;
    assign vertice1_depth_update = out_q[0].depth;
    assign vertice1_color_update = out_q[0].color;
    assign vertice2_x_update     = out_q[1].x;
    assign vertice2_y_update     = out_q[1].y;
    assign vertice2_depth_update = out_q[1].depth;
    assign vertice2_color_update = out_q[1].color;
    assign vertice3_x_update     = out_q[2].x;
    assign vertice3_y_update     = out_q[2].y;
    assign vertice3_depth_update = out_q[2].depth;
    assign vertice3_color_update = out_q[2].color;

endmodule

// File: tb/tb_vertex_shader.sv
// Bench for vertex_shader: triangle-level reference model checked every cycle,
// plus directed vectors with hand-computed screen coordinates.
module tb_vertex_shader;

    typedef struct {
        int x;
        int y;
        int d;
        int c;
    } vtx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        to_shader_valid = 1'b0;
    logic [19:0] to_shader_vertice_info = '0;
    logic [19:0] address_sram_get_vertex;
    logic        sram_rd_en;
    logic [71:0] sram_rd_data = '0;
    logic [11:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [20:0] v1d, v2d, v3d;
    logic [23:0] v1c, v2c, v3c;
    logic        data_ready, overrun;

    int errors = 0;
    int checks = 0;

    vertex_shader dut (
        .clk                     (clk),
        .rst                     (rst),
        .to_shader_valid         (to_shader_valid),
        .to_shader_vertice_info  (to_shader_vertice_info),
        .address_sram_get_vertex (address_sram_get_vertex),
        .sram_rd_en              (sram_rd_en),
        .sram_rd_data            (sram_rd_data),
        .vertice1_x_update       (v1x),
        .vertice1_y_update       (v1y),
        .vertice1_depth_update   (v1d),
        .vertice1_color_update   (v1c),
        .vertice2_x_update       (v2x),
        .vertice2_y_update       (v2y),
        .vertice2_depth_update   (v2d),
        .vertice2_color_update   (v2c),
        .vertice3_x_update       (v3x),
        .vertice3_y_update       (v3y),
        .vertice3_depth_update   (v3d),
        .vertice3_color_update   (v3c),
        .data_ready              (data_ready),
        .overrun                 (overrun)
    );

    always #5 clk = ~clk;

    // Vertex memory and a two-cycle-latency SRAM.
    logic [71:0] mem [0:15];
    logic [71:0] sram_d1 = '0;

    function automatic logic [71:0] mk(input int x, input int y, input int z, input int c);
        return {16'(x), 16'(y), 16'(z), 24'(c)};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[5]  = mk(100, 50, -10, 'hFF8000);
        mem[6]  = mk(2000, -600, 32767, 'h123456);
        mem[7]  = mk(-1000, 600, 0, 'hABCDEF);
        mem[8]  = mk(0, 0, -32768, 'h000001);
        mem[9]  = mk(959, -539, 1, 'hC0FFEE);
        mem[10] = mk(-960, 541, -1, 'h00FF00);
        mem[11] = mk(-961, 540, 100, 'h0000FF);
    end

    always @(posedge clk) begin
        sram_d1      <= sram_rd_en ? mem[address_sram_get_vertex[3:0]] : '0;
        sram_rd_data <= sram_d1;
    end

    // Reference transform in plain integer arithmetic.
    function automatic vtx_t model_xf(input logic [71:0] w);
        vtx_t r;
        int x, y, z;
        x = int'($signed(w[71:56]));
        y = int'($signed(w[55:40]));
        z = int'($signed(w[39:24]));
        r.x = ((x * 256) >>> 8) + 960;
        if (r.x < 0) r.x = 0;
        if (r.x > 1919) r.x = 1919;
        r.y = 540 - ((y * 256) >>> 8);
        if (r.y < 0) r.y = 0;
        if (r.y > 1079) r.y = 1079;
        r.d = 1048576 + z;
        r.c = int'(w[23:0]);
        return r;
    endfunction

    function automatic logic [68:0] pack(input vtx_t v);
        return {12'(v.x), 12'(v.y), 21'(v.d), 24'(v.c)};
    endfunction

    // Triangle-level model: a triangle commits 4 edges after its third index
    // unless a new triangle starts first; a new triangle within 4 edges of the
    // previous index is an overrun.
    int          n = 0;
    int          last_v = -1000;
    int          mslot = 0;
    int          pend_edge = 0;
    bit          pend_valid = 0, clr_next = 0, exp_dr = 0, exp_ovr = 0, exp_rd_en = 0, committed;
    logic [19:0] exp_addr = '0;
    vtx_t        cur [3];
    vtx_t        pend [3];
    vtx_t        exp_out [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            exp_out[i] = '{0, 0, 0, 0};
            cur[i]     = '{0, 0, 0, 0};
            pend[i]    = '{0, 0, 0, 0};
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                last_v = -1000; mslot = 0; pend_valid = 0; clr_next = 0;
                exp_dr = 0; exp_ovr = 0; exp_rd_en = 0; exp_addr = '0;
                for (int i = 0; i < 3; i++) exp_out[i] = '{0, 0, 0, 0};
            end else begin
                n++;
                committed = 0;
                if (clr_next) begin
                    exp_dr = 0;
                    clr_next = 0;
                end
                if (pend_valid && n == pend_edge) begin
                    exp_out = pend;
                    exp_dr = 1;
                    pend_valid = 0;
                    committed = 1;
                end
                exp_rd_en = to_shader_valid;
                if (to_shader_valid) begin
                    exp_addr = to_shader_vertice_info;
                    cur[mslot] = model_xf(mem[to_shader_vertice_info[3:0]]);
                    if (mslot == 0) begin
                        if (n - last_v <= 4) exp_ovr = 1;
                        pend_valid = 0;
                        if (committed) clr_next = 1;
                        else exp_dr = 0;
                    end
                    if (mslot == 2) begin
                        pend = cur;
                        pend_valid = 1;
                        pend_edge = n + 4;
                    end
                    last_v = n;
                    mslot = (mslot + 1) % 3;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("data_ready", 128'(data_ready), 128'(exp_dr));
        check("overrun", 128'(overrun), 128'(exp_ovr));
        check("sram_rd_en", 128'(sram_rd_en), 128'(exp_rd_en));
        if (exp_rd_en) check("address", 128'(address_sram_get_vertex), 128'(exp_addr));
        check("vertex1", 128'({v1x, v1y, v1d, v1c}), 128'(pack(exp_out[0])));
        check("vertex2", 128'({v2x, v2y, v2d, v2c}), 128'(pack(exp_out[1])));
        check("vertex3", 128'({v3x, v3y, v3d, v3c}), 128'(pack(exp_out[2])));
    end

    task automatic pulse(input int idx);
        to_shader_valid = 1'b1;
        to_shader_vertice_info = 20'(idx);
        @(posedge clk);
        #1;
        to_shader_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_dr", 128'(data_ready), 0);
        check("rst_ovr", 128'(overrun), 0);
        check("rst_v1x", 128'(v1x), 0);
        check("rst_addr", 128'(address_sram_get_vertex), 0);
        rst = 1'b0;
        idle(2);

        // Back-to-back triangle 5,6,7
        pulse(5);
        check("addr_5", 128'(address_sram_get_vertex), 5);
        check("rden_5", 128'(sram_rd_en), 1);
        pulse(6);
        check("addr_6", 128'(address_sram_get_vertex), 6);
        pulse(7);
        check("addr_7", 128'(address_sram_get_vertex), 7);
        idle(3);
        check("dr_early", 128'(data_ready), 0);
        idle(1);
        check("dr_at_5", 128'(data_ready), 1);
        check("a_v1x", 128'(v1x), 1060);
        check("a_v1y", 128'(v1y), 490);
        check("a_v1d", 128'(v1d), 'h0FFFF6);
        check("a_v1c", 128'(v1c), 'hFF8000);
        check("a_v2x_clamp", 128'(v2x), 1919);
        check("a_v2y_clamp", 128'(v2y), 1079);
        check("a_v2d_max", 128'(v2d), 'h107FFF);
        check("a_v3x_clamp", 128'(v3x), 0);
        check("a_v3y_clamp", 128'(v3y), 0);
        check("a_v3c", 128'(v3c), 'hABCDEF);

        idle(20);
        check("dr_held", 128'(data_ready), 1);

        // Spaced triangle 8,9,10
        pulse(8);
        check("dr_drop", 128'(data_ready), 0);
        check("hold_v1x", 128'(v1x), 1060);
        idle(3);
        pulse(9);
        idle(3);
        pulse(10);
        idle(3);
        check("b_dr_early", 128'(data_ready), 0);
        idle(1);
        check("b_dr", 128'(data_ready), 1);
        check("b_v1x", 128'(v1x), 960);
        check("b_v1y", 128'(v1y), 540);
        check("b_v1d_min", 128'(v1d), 'h0F8000);
        check("b_v2x_edge", 128'(v2x), 1919);
        check("b_v2y_edge", 128'(v2y), 1079);
        check("b_v3x_edge", 128'(v3x), 0);
        check("b_v3y_neg", 128'(v3y), 0);
        check("b_v3d", 128'(v3d), 'h0FFFFF);
        check("b_no_ovr", 128'(overrun), 0);

        // Overrun: new triangle while the old one is in flight
        idle(2);
        pulse(5);
        pulse(6);
        pulse(7);
        idle(1);
        pulse(11);
        check("ovr_set", 128'(overrun), 1);
        pulse(9);
        pulse(10);
        check("ovr_no_old_commit", 128'(data_ready), 0);
        check("ovr_hold_v1x", 128'(v1x), 960);
        idle(4);
        check("ovr_new_dr", 128'(data_ready), 1);
        check("ovr_v1x", 128'(v1x), 0);
        check("ovr_v1d", 128'(v1d), 'h100064);
        check("ovr_v2x", 128'(v2x), 1919);
        check("ovr_v3c", 128'(v3c), 'h00FF00);

        // Asynchronous reset mid-triangle
        idle(10);
        pulse(5);
        pulse(6);
        #3;
        rst = 1'b1;
        #1;
        check("arst_dr", 128'(data_ready), 0);
        check("arst_ovr", 128'(overrun), 0);
        check("arst_v1x", 128'(v1x), 0);
        check("arst_v3c", 128'(v3c), 0);
        check("arst_rden", 128'(sram_rd_en), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        pulse(9);
        pulse(10);
        pulse(11);
        idle(4);
        check("post_rst_dr", 128'(data_ready), 1);
        check("post_rst_v1x", 128'(v1x), 1919);
        check("post_rst_v1d", 128'(v1d), 'h100001);
        check("post_rst_v2d", 128'(v2d), 'h0FFFFF);
        check("post_rst_v3y", 128'(v3y), 0);
        check("post_rst_ovr", 128'(overrun), 0);

        // New triangle on the same edge as the previous commit
        idle(10);
        pulse(5);
        pulse(6);
        pulse(7);
        idle(3);
        pulse(8);
        check("sim_commit_dr", 128'(data_ready), 1);
        check("sim_commit_v1x", 128'(v1x), 1060);
        check("sim_ovr", 128'(overrun), 1);
        idle(1);
        check("sim_clear_dr", 128'(data_ready), 0);

        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vertex_shader.md
Name: vertex_shader

Overview:
- Sits between the face-fetch controller and the rasterizer.
- Receives three vertex indices per triangle as single-cycle pulses, fetches each vertex record from vertex SRAM, and transforms model coordinates to screen x/y and unsigned depth. Color passes through.
- Presents all three transformed vertices plus a level data_ready flag to the controller, which latches them when the rasterizer requests the next triangle.

Parameters:
- SRAM_LAT, 2: cycles from registered read address to valid sram_rd_data.
- SCALE, 256: signed 16-bit fixed-point coordinate scale.
- FRAC, 8: right arithmetic shift applied after the scale multiply.
- X_OFF, 960: screen x offset.
- Y_OFF, 540: screen y offset (y is flipped).
- SCREEN_W, 1920: x clamp bound (max x = SCREEN_W-1).
- SCREEN_H, 1080: y clamp bound (max y = SCREEN_H-1).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- to_shader_valid  input  1  vertex index strobe.
- to_shader_vertice_info  input  20  vertex index.
- address_sram_get_vertex  output  20  vertex SRAM read address.
- sram_rd_en  output  1  read strobe.
- sram_rd_data  input  72  vertex word: [71:56] x s16, [55:40] y s16, [39:24] z s16, [23:0] color.
- vertice{1,2,3}_x_update  output  12 each  screen x.
- vertice{1,2,3}_y_update  output  12 each  screen y.
- vertice{1,2,3}_depth_update  output  21 each  depth.
- vertice{1,2,3}_color_update  output  24 each  color.
- data_ready  output  1  all three outputs valid for the current triangle.
- overrun  output  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values:
  - All outputs 0; data_ready 0; overrun 0.
  - Slot counter 0; read-tag pipeline cleared.
  - Reset mid-triangle discards all in-flight reads and staging data.
- Slot counter (0..2) tags each valid pulse as vertex 1/2/3 and wraps 2→0.
  - A valid with slot=0 clears data_ready on the next edge. The previous triangle's output registers stay unchanged until overwritten.
- Read issue:
  - Valid at cycle t → address_sram_get_vertex = index and sram_rd_en = 1 at t+1.
  - A tag {valid, slot} enters a SRAM_LAT+1 deep shift pipeline.
- Return: at t+1+SRAM_LAT the tag pops and sram_rd_data is captured into the transform stage.
- Transform (registered, lands in staging slot at t+2+SRAM_LAT):
  - sx = ((x*SCALE) >>> FRAC) + X_OFF, computed in signed 34 bits. Clamp: <0 → 0; >SCREEN_W-1 → SCREEN_W-1; truncate to 12.
  - sy = Y_OFF - ((y*SCALE) >>> FRAC), same width and clamp against SCREEN_H-1.
  - depth = 2^20 + sign_ext21(z). Always in range; no clamp.
  - color passes through unchanged.
- Commit:
  - When slot 2 is written to staging, all staging copies to the output registers and data_ready=1 at t+3+SRAM_LAT, where t is the third valid.
  - With SRAM_LAT=2: 5 cycles after the third valid.
  - data_ready is a level held until the next slot-0 valid. There is no consume handshake; the controller samples in its WAITING state.
- Back-to-back valids (one per cycle) are fully pipelined; no stall and no ready output.
- Protocol violation: a slot-0 valid while any tag is still in flight, or staging incomplete for the previous triangle.
  - overrun=1 (sticky until reset).
  - The new triangle is still accepted; the old partial triangle is dropped, with no commit for it.
- Valid with slot≠0 while data_ready=1 is impossible by construction; no special handling.
- Simultaneous slot-0 valid and commit of the previous triangle: the commit happens (data_ready=1), then the clear from the valid wins one edge later. overrun is set because a tag was in flight.

Decomposition:
- Shared package vs_pkg holds:
  - VTX_W=72 and the field offsets of the vertex word.
  - Coordinate widths (12, 21, 24).
  - A vertex_out struct {x, y, depth, color}.
- One natural sub-module, vs_transform: a single vertex's registered multiply/shift/offset/clamp. Instantiate once (time-shared via slot tag).

Test Plan:
- Identity (SCALE=256, FRAC=8). Indices 5,6,7 on consecutive cycles; SRAM returns:
  - v1 (x=100, y=50, z=-10, color=0xFF8000) → x=1060, y=490, depth=0x0FFFF6, color 0xFF8000.
  - data_ready rises exactly 5 cycles after the index-7 pulse.
  - address sequence 5,6,7 on consecutive cycles with sram_rd_en high.
- Clamp: x=2000 → 1919; x=-1000 → 0; y=-600 → 1079; y=600 → 0; z=32767 → depth 0x107FFF.
- Spaced valids (3-cycle gaps): same results. data_ready held high for 20 idle cycles; the next slot-0 valid drops it one edge later while outputs are unchanged until the new commit.
- Overrun: a 4th valid one cycle after the 3rd (tags in flight) → overrun=1; no commit for the old triangle; the following two valids complete the new triangle normally.
- Reset asserted mid-triangle (after 2 valids, asynchronously between edges) → all outputs 0 immediately. A fresh 3-valid sequence afterwards commits correctly with no stale slot data.
